// File: rtl/enemy_move_sched_pkg.sv
// Shared types and constants for the enemy-tank move scheduler.
package enemy_move_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_WR_DST,
    S_WR_SRC,
    S_REPLY,
    S_CLR
  } state_t;

  localparam int TILE_EMPTY    = 0;
  localparam int MAP_DEPTH_DEF = 192;

endpackage

// File: rtl/enemy_req_arbiter.sv
// Picks one move requester, searching upward (with wrap) from ptr_i.
// A zero pointer gives plain fixed priority, lowest index first.
module enemy_req_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             vld_o
);

  int j;

  always_comb begin
    vld_o = 1'b0;
    idx_o = '0;
    j     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(ptr_i) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!vld_o && req_i[j]) begin
        vld_o = 1'b1;
        idx_o = IDX_W'(j);
      end
    end
    grant_o = vld_o ? (N_REQ'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/enemy_move_sched.sv
// Serialises enemy-tank moves and bullet tile-clears onto one map RAM port.
// ENEMY_RR_ARB_EN selects round-robin arbitration; otherwise fixed priority.
module enemy_move_sched
  import enemy_move_sched_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 3,
  parameter int MAP_DEPTH = MAP_DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] src_addr,
  input  logic [N_REQ*ADDR_W-1:0] dst_addr,
  output logic [N_REQ-1:0]        ack,
  output logic                    ok,
  input  logic                    clr_req,
  input  logic [ADDR_W-1:0]       clr_addr,
  output logic                    clr_ack,
  output logic [ADDR_W-1:0]       ram_rd_addr,
  input  logic [DATA_W-1:0]       ram_rd_data,
  output logic [ADDR_W-1:0]       ram_wr_addr,
  output logic [DATA_W-1:0]       ram_wr_data,
  output logic                    ram_we,
  output logic                    busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic [N_REQ-1:0]   gnt_oh_q, gnt_oh_d;
  logic [ADDR_W-1:0]  src_q, src_d;
  logic [ADDR_W-1:0]  dst_q, dst_d;
  logic               ok_q, ok_d;

  logic [N_REQ-1:0]   arb_oh;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_vld;
  logic [IDX_W-1:0]   ptr;
  logic               reject;

`ifdef ENEMY_RR_ARB_EN
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  enemy_req_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
    .req_i   (req),
    .ptr_i   (ptr),
    .grant_o (arb_oh),
    .idx_o   (arb_idx),
    .vld_o   (arb_vld)
  );

  // Out-of-map, null moves and occupied targets are all refused.
  assign reject = (32'(dst_q) >= 32'(MAP_DEPTH)) || (32'(src_q) >= 32'(MAP_DEPTH)) ||
                  (src_q == dst_q) || (ram_rd_data != DATA_W'(TILE_EMPTY));

  assign busy = (state_q != S_IDLE);

  always_comb begin
    state_d     = state_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_oh_d    = gnt_oh_q;
    src_d       = src_q;
    dst_d       = dst_q;
    ok_d        = ok_q;
`ifdef ENEMY_RR_ARB_EN
    ptr_d       = ptr_q;
`endif
    ack         = '0;
    ok          = 1'b0;
    clr_ack     = 1'b0;
    ram_we      = 1'b0;
    ram_rd_addr = '0;
    ram_wr_addr = '0;
    ram_wr_data = '0;

    case (state_q)
      S_IDLE: begin
        if (clr_req) begin
          state_d = S_CLR;
        end else if (arb_vld) begin
          gnt_idx_d = arb_idx;
          gnt_oh_d  = arb_oh;
          src_d     = src_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
          dst_d     = dst_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
          state_d   = S_CHECK;
        end
      end
      S_CLR: begin
        ram_we      = (32'(clr_addr) < 32'(MAP_DEPTH));
        ram_wr_addr = clr_addr;
        ram_wr_data = DATA_W'(TILE_EMPTY);
        clr_ack     = 1'b1;
        state_d     = S_IDLE;
      end
      S_CHECK: begin
        ram_rd_addr = dst_q;
        ok_d        = !reject;
        state_d     = reject ? S_REPLY : S_WR_DST;
      end
      S_WR_DST: begin
        ram_we      = 1'b1;
        ram_wr_addr = dst_q;
        ram_wr_data = DATA_W'(32'(gnt_idx_q) + 1);
        state_d     = S_WR_SRC;
      end
      S_WR_SRC: begin
        ram_we      = 1'b1;
        ram_wr_addr = src_q;
        ram_wr_data = DATA_W'(TILE_EMPTY);
        state_d     = S_REPLY;
      end
      S_REPLY: begin
        ack     = gnt_oh_q;
        ok      = ok_q;
`ifdef ENEMY_RR_ARB_EN
        ptr_d   = (32'(gnt_idx_q) == N_REQ - 1) ? '0 : IDX_W'(32'(gnt_idx_q) + 1);
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      gnt_idx_q <= '0;
      gnt_oh_q  <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      ok_q      <= 1'b0;
`ifdef ENEMY_RR_ARB_EN
      ptr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_oh_q  <= gnt_oh_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      ok_q      <= ok_d;
`ifdef ENEMY_RR_ARB_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

endmodule
